// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
//   MemBase   : byte address that maps to SRAM word 0
//   SramAddrW : external SRAM halfword address width
//   SramDataW : external SRAM data bus width
//   CntW      : width of the per-access wait counter
//   state_e   : controller state encoding
package mem_stage_sram_ctrl_pkg;

  localparam int unsigned MemBase   = 1024;
  localparam int unsigned SramAddrW = 18;
  localparam int unsigned SramDataW = 16;
  localparam int unsigned CntW      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-cycle counter for one 16-bit SRAM access.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clear : synchronous clear (restart at 0)
//   tc    : high while the count equals SRAM_WAIT-1
module sram_wait_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == CntW'(SRAM_WAIT - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage data-memory controller: splits one 32-bit load/store into two
// 16-bit SRAM accesses (low halfword first) and freezes the pipeline meanwhile.
//   clk, rst    : clock and synchronous active-high reset
//   ALU_Res     : byte address from EXE/MEM
//   Val_Rm      : store data
//   MEM_R_EN    : load request
//   MEM_W_EN    : store request (wins over load)
//   mem_rd_data : last completed load word
//   ready       : 0 freezes the pipeline registers
//   SRAM_ADDR   : halfword address {word, half}
//   SRAM_DQ     : bidirectional SRAM data bus
//   SRAM_WE_N   : active-low write strobe
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_LEN = 32,
  parameter int unsigned SRAM_WAIT   = 2,
  parameter int unsigned MEM_BASE    = MemBase
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] ALU_Res,
  input  logic [ADDRESS_LEN-1:0] Val_Rm,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  output logic [ADDRESS_LEN-1:0] mem_rd_data,
  output logic                   ready,
  output logic [SramAddrW-1:0]   SRAM_ADDR,
  inout  wire  [SramDataW-1:0]   SRAM_DQ,
  output logic                   SRAM_WE_N
);

  state_e state_q, state_d;
  logic   is_write_q;
  logic   tc;
  logic   req;
  logic   active;
  logic   half;
  logic   dq_oe;
  logic   [SramDataW-1:0]   dq_out;
  logic   [ADDRESS_LEN-1:0] offset;
  logic   [ADDRESS_LEN-1:0] rd_data_q;
  logic   unused_offset;

  assign req = MEM_R_EN | MEM_W_EN;

  // Counter restarts whenever we are not mid-halfword or a halfword just ended.
  sram_wait_counter #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (!active || tc),
    .tc    (tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = StLow;
      StLow:   if (tc)  state_d = StHigh;
      StHigh:  if (tc)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    active = 1'b0;
    half   = 1'b0;
    ready  = 1'b0;
    unique case (state_q)
      StIdle:  ready = !req;
      StLow:   active = 1'b1;
      StHigh:  begin active = 1'b1; half = 1'b1; end
      StDone:  ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  // Wrapping subtraction; only word bits [16:0] reach the 18-bit halfword bus.
  assign offset        = ALU_Res - ADDRESS_LEN'(MEM_BASE);
  assign unused_offset = ^{offset[ADDRESS_LEN-1:19], offset[1:0]};

  assign SRAM_ADDR = active ? {offset[18:2], half} : '0;
  assign SRAM_WE_N = !(active && is_write_q);
  assign dq_oe     = active && is_write_q;
  assign dq_out    = half ? Val_Rm[31:16] : Val_Rm[15:0];
  assign SRAM_DQ   = dq_oe ? dq_out : {SramDataW{1'bz}};

  // Request type is captured on entry so it stays fixed for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (state_q == StIdle && req) begin
        is_write_q <= MEM_W_EN;
      end
      if (!is_write_q && tc && state_q == StLow) begin
        rd_data_q[15:0] <= SRAM_DQ;
      end
      if (!is_write_q && tc && state_q == StHigh) begin
        rd_data_q[31:16] <= SRAM_DQ;
      end
    end
  end

  assign mem_rd_data = rd_data_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM model.
module tb_mem_stage_sram_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] alu_res;
  logic [31:0] val_rm;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;

  // SRAM model: drives the bus when model_en; decoy returns the inverted word
  // so sampling on a non-final wait cycle is caught.
  logic [15:0] mem [0:255];
  logic        model_en;
  logic        decoy;
  logic [15:0] model_word;
  wire         unused_tb = ^sram_addr[17:8];

  assign model_word = decoy ? ~mem[sram_addr[7:0]] : mem[sram_addr[7:0]];
  assign sram_dq    = model_en ? model_word : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
  end

  mem_stage_sram_ctrl #(
    .ADDRESS_LEN (32),
    .SRAM_WAIT   (2),
    .MEM_BASE    (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ALU_Res     (alu_res),
    .Val_Rm      (val_rm),
    .MEM_R_EN    (mem_r_en),
    .MEM_W_EN    (mem_w_en),
    .mem_rd_data (mem_rd_data),
    .ready       (ready),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ     (sram_dq),
    .SRAM_WE_N   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          r;
    bit          w;
    bit          men;
    bit          dec;
    logic [31:0] alu;
    logic [31:0] val;
    bit          rdy;
    bit          we_n;
    logic [17:0] addr;
    bit          cdq;
    logic [15:0] dq;
    bit          crd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  task automatic add(input bit rst_, r_, w_, men_, dec_, input logic [31:0] alu_, val_,
                     input bit rdy_, we_, input logic [17:0] addr_, input bit cdq_,
                     input logic [15:0] dq_, input bit crd_, input logic [31:0] rd_);
    vecs.push_back('{rst_, r_, w_, men_, dec_, alu_, val_, rdy_, we_, addr_, cdq_, dq_,
                     crd_, rd_});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, settle, outputs are then checkable.
  task automatic cyc(input bit rst_, r_, w_, input logic [31:0] alu_, val_,
                     input bit men_, dec_);
    @(negedge clk);
    rst      = rst_;
    mem_r_en = r_;
    mem_w_en = w_;
    alu_res  = alu_;
    val_rm   = val_;
    model_en = men_;
    decoy    = dec_;
    #1;
  endtask

  localparam logic [31:0] AdrA = 32'd1024;
  localparam logic [31:0] AdrB = 32'd1036;
  localparam logic [31:0] DatA = 32'hDEADBEEF;
  localparam logic [31:0] DatB = 32'h12345678;
  localparam logic [31:0] DatC = 32'hCAFEF00D;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    alu_res  = '0;
    val_rm   = '0;
    model_en = 1'b0;
    decoy    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Reset, then idle
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    // Store DEADBEEF at 1024
    add(0, 0, 1, 0, 0, AdrA, DatA, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, AdrA, DatA, 0, 0, 0, 1, 16'hBEEF, 0, 0);
    add(0, 0, 1, 0, 0, AdrA, DatA, 0, 0, 0, 1, 16'hBEEF, 0, 0);
    add(0, 0, 1, 0, 0, AdrA, DatA, 0, 0, 1, 1, 16'hDEAD, 0, 0);
    add(0, 0, 1, 0, 0, AdrA, DatA, 0, 0, 1, 1, 16'hDEAD, 0, 0);
    add(0, 0, 1, 0, 0, AdrA, DatA, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, AdrA, DatA, 1, 1, 0, 0, 0, 1, 0);
    // Load from 1024; decoy data on the first wait cycle of each half
    add(0, 1, 0, 0, 0, AdrA, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, AdrA, 0, 0, 1, 0, 1, 16'h4110, 0, 0);
    add(0, 1, 0, 1, 0, AdrA, 0, 0, 1, 0, 1, 16'hBEEF, 0, 0);
    add(0, 1, 0, 1, 1, AdrA, 0, 0, 1, 1, 1, 16'h2152, 0, 0);
    add(0, 1, 0, 1, 0, AdrA, 0, 0, 1, 1, 1, 16'hDEAD, 0, 0);
    add(0, 1, 0, 0, 0, AdrA, 0, 1, 1, 0, 0, 0, 1, DatA);
    add(0, 0, 0, 0, 0, AdrA, 0, 1, 1, 0, 0, 0, 1, DatA);
    // Store at 1036 -> word 3, halfwords 6 and 7
    add(0, 0, 1, 0, 0, AdrB, DatB, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, AdrB, DatB, 0, 0, 6, 1, 16'h5678, 0, 0);
    add(0, 0, 1, 0, 0, AdrB, DatB, 0, 0, 6, 1, 16'h5678, 0, 0);
    add(0, 0, 1, 0, 0, AdrB, DatB, 0, 0, 7, 1, 16'h1234, 0, 0);
    add(0, 0, 1, 0, 0, AdrB, DatB, 0, 0, 7, 1, 16'h1234, 0, 0);
    add(0, 0, 1, 0, 0, AdrB, DatB, 1, 1, 0, 0, 0, 1, DatA);
    add(0, 0, 0, 0, 0, AdrB, DatB, 1, 1, 0, 0, 0, 1, DatA);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].r, vecs[i].w, vecs[i].alu, vecs[i].val, vecs[i].men,
          vecs[i].dec);
      chk($sformatf("v%0d ready", i), {31'd0, ready}, {31'd0, vecs[i].rdy});
      chk($sformatf("v%0d we_n", i), {31'd0, sram_we_n}, {31'd0, vecs[i].we_n});
      chk($sformatf("v%0d addr", i), {14'd0, sram_addr}, {14'd0, vecs[i].addr});
      if (vecs[i].cdq) chk($sformatf("v%0d dq", i), {16'd0, sram_dq}, {16'd0, vecs[i].dq});
      if (vecs[i].crd) chk($sformatf("v%0d rd", i), mem_rd_data, vecs[i].rd);
    end

    // Back-to-back: load from 1036, then store at 1024 right after DONE
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, AdrB, 0, (i >= 1 && i <= 4), 0);
      chk($sformatf("b2b ld c%0d ready", i), {31'd0, ready}, {31'd0, (i == 5)});
    end
    chk("b2b ld rd", mem_rd_data, DatB);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, AdrA, DatC, 0, 0);
      chk($sformatf("b2b st c%0d ready", i), {31'd0, ready}, {31'd0, (i == 5)});
      if (i == 1) chk("b2b st we_n", {31'd0, sram_we_n}, 32'd0);
    end
    chk("b2b st keeps rd", mem_rd_data, DatB);
    cyc(0, 0, 0, AdrA, 0, 0, 0);

    // Reset in the second HIGH cycle of a load
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, AdrA, 0, (i >= 1), 0);
    cyc(1, 1, 0, AdrA, 0, 1, 0);
    cyc(0, 0, 0, AdrA, 0, 0, 0);
    chk("rst mid ready", {31'd0, ready}, 32'd1);
    chk("rst mid we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst mid addr", {14'd0, sram_addr}, 32'd0);
    chk("rst mid rd", mem_rd_data, 32'd0);
    // Controller must be back in IDLE: a new request drops ready at once
    cyc(0, 1, 0, AdrA, 0, 0, 0);
    chk("post rst idle ready", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, AdrA, 0, 1, 0);
    cyc(0, 1, 0, AdrA, 0, 0, 0);
    chk("post rst done ready", {31'd0, ready}, 32'd1);
    chk("post rst load rd", mem_rd_data, DatC);
    cyc(0, 0, 0, AdrA, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
